// File: rtl/ptp_irq_pkg.sv
// Shared register offsets, coalescing FSM state type and counter widths
// for the PTP interrupt controller.
package ptp_irq_pkg;

  localparam logic [31:0] IRQ_STATUS_OFS   = 32'd0;
  localparam logic [31:0] IRQ_MASK_OFS     = 32'd1;
  localparam logic [31:0] IRQ_MODE_OFS     = 32'd2;
  localparam logic [31:0] IRQ_RAW_OFS      = 32'd3;
  localparam logic [31:0] IRQ_FORCE_OFS    = 32'd4;
  localparam logic [31:0] IRQ_COAL_THR_OFS = 32'd5;
  localparam logic [31:0] IRQ_COAL_TMO_OFS = 32'd6;

  localparam int COAL_CNT_W = 8;
  localparam int COAL_TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ASSERT = 2'd2
  } irq_coal_state_t;

endpackage

// File: rtl/ptp_irq_sync.sv
// Per-source synchroniser chain plus one delay flop for rising-edge detection.
// Edges are suppressed until the chain has refilled after reset.
module ptp_irq_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             bus2ip_clk,
  input  logic             bus2ip_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] sync_d;
  logic [STAGES:0]  fill_q;

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      sync_d <= '0;
      fill_q <= '0;
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      sync_d <= stage_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign sync = stage_q[STAGES-1];
  // A source held high through reset must not look like a fresh edge.
  assign rise = fill_q[STAGES] ? (sync & ~sync_d) : '0;

endmodule

// File: rtl/ptp_irq_ctl.sv
// PTP interrupt controller: edge/level sources, W1C status, force, mask.
// Optional interrupt coalescing is built when PTP_IRQ_COALESCE_EN is defined.
module ptp_irq_ctl
  import ptp_irq_pkg::*;
#(
  parameter int          NUM_SRC       = 8,
  parameter logic [31:0] INT_BASE_ADDR = 32'h300,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic               bus2ip_clk,
  input  logic               bus2ip_rst,
  input  logic [31:0]        bus2ip_addr_i,
  input  logic [31:0]        bus2ip_data_i,
  input  logic               bus2ip_rd_ce_i,
  input  logic               bus2ip_wr_ce_i,
  output logic [31:0]        ip2bus_data_o,
  input  logic [NUM_SRC-1:0] int_src_i,
  output logic               int_ptp_o
);

  logic [NUM_SRC-1:0] status_q, mask_q, mode_q;
  logic [NUM_SRC-1:0] src_sync, src_rise;
  logic [NUM_SRC-1:0] w1c_bits, force_bits, set_event;
  logic [31:0]        ofs, rd_mux;
  logic               wr_status, wr_mask, wr_mode, wr_force;
  logic               unused_wdata;

`ifdef PTP_IRQ_COALESCE_EN
  logic [COAL_CNT_W-1:0] coal_thr_q, cnt_q, cnt_n;
  logic [COAL_TMO_W-1:0] coal_tmo_q, tmr_q, tmr_n;
  irq_coal_state_t       state_q, state_n;
  logic                  evt, pending;
`endif

  ptp_irq_sync #(
    .WIDTH (NUM_SRC),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .bus2ip_clk(bus2ip_clk),
    .bus2ip_rst(bus2ip_rst),
    .async_in  (int_src_i),
    .sync      (src_sync),
    .rise      (src_rise)
  );

  // Addresses below the base wrap to huge offsets and decode as unmapped.
  assign ofs          = bus2ip_addr_i - INT_BASE_ADDR;
  assign wr_status    = bus2ip_wr_ce_i && (ofs == IRQ_STATUS_OFS);
  assign wr_mask      = bus2ip_wr_ce_i && (ofs == IRQ_MASK_OFS);
  assign wr_mode      = bus2ip_wr_ce_i && (ofs == IRQ_MODE_OFS);
  assign wr_force     = bus2ip_wr_ce_i && (ofs == IRQ_FORCE_OFS);
  assign unused_wdata = ^bus2ip_data_i;

  assign w1c_bits   = wr_status ? bus2ip_data_i[NUM_SRC-1:0] : '0;
  assign force_bits = wr_force ? bus2ip_data_i[NUM_SRC-1:0] : '0;
  assign set_event  = (mode_q & src_sync) | (~mode_q & src_rise) | force_bits;

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      status_q <= '0;
      mask_q   <= '1;
      mode_q   <= '0;
    end else begin
      // A set arriving together with its W1C keeps the bit set.
      status_q <= (status_q & ~w1c_bits) | set_event;
      if (wr_mask) mask_q <= bus2ip_data_i[NUM_SRC-1:0];
      if (wr_mode) mode_q <= bus2ip_data_i[NUM_SRC-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ofs)
      IRQ_STATUS_OFS:   rd_mux = 32'(status_q);
      IRQ_MASK_OFS:     rd_mux = 32'(mask_q);
      IRQ_MODE_OFS:     rd_mux = 32'(mode_q);
      IRQ_RAW_OFS:      rd_mux = 32'(src_sync);
`ifdef PTP_IRQ_COALESCE_EN
      IRQ_COAL_THR_OFS: rd_mux = 32'(coal_thr_q);
      IRQ_COAL_TMO_OFS: rd_mux = 32'(coal_tmo_q);
`endif
      default:          rd_mux = '0;
    endcase
  end

  assign ip2bus_data_o = bus2ip_rd_ce_i ? rd_mux : '0;

`ifdef PTP_IRQ_COALESCE_EN
  assign evt     = |(set_event & mask_q);
  assign pending = |(status_q & mask_q);

  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      coal_thr_q <= COAL_CNT_W'(1);
      coal_tmo_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      int_ptp_o  <= 1'b0;
    end else begin
      if (bus2ip_wr_ce_i && (ofs == IRQ_COAL_THR_OFS))
        coal_thr_q <= bus2ip_data_i[COAL_CNT_W-1:0];
      if (bus2ip_wr_ce_i && (ofs == IRQ_COAL_TMO_OFS))
        coal_tmo_q <= bus2ip_data_i[COAL_TMO_W-1:0];
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      tmr_q     <= tmr_n;
      int_ptp_o <= (state_q == ASSERT);
    end
  end

  // Thresholds compare against the post-increment count and timer.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    tmr_n   = tmr_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          cnt_n   = COAL_CNT_W'(1);
          tmr_n   = '0;
          state_n = (coal_thr_q <= COAL_CNT_W'(1)) ? ASSERT : ACCUM;
        end
      end
      ACCUM: begin
        if (evt && (cnt_q != '1)) cnt_n = cnt_q + 1'b1;
        if (tmr_q != '1) tmr_n = tmr_q + 1'b1;
        if ((cnt_n >= coal_thr_q) || ((coal_tmo_q != '0) && (tmr_n >= coal_tmo_q)))
          state_n = ASSERT;
        else if (!pending)
          state_n = IDLE;
      end
      ASSERT: begin
        if (!pending) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
`else
  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) int_ptp_o <= 1'b0;
    else            int_ptp_o <= |(status_q & mask_q);
  end
`endif

endmodule

// File: tb/tb_ptp_irq_ctl.sv
// Self-checking bench for ptp_irq_ctl: register table, directed latency
// sequences, and randomized traffic against a sample-history reference model.
`timescale 1ns/1ps
module tb_ptp_irq_ctl;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h300;
  localparam int          S    = 2;
`ifdef PTP_IRQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr, wdata, rdata;
  logic          rd_ce, wr_ce;
  logic [N-1:0]  src;
  logic          irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ptp_irq_ctl #(
    .NUM_SRC      (N),
    .INT_BASE_ADDR(BASE),
    .SYNC_STAGES  (S)
  ) dut (
    .bus2ip_clk    (clk),
    .bus2ip_rst    (rst),
    .bus2ip_addr_i (addr),
    .bus2ip_data_i (wdata),
    .bus2ip_rd_ce_i(rd_ce),
    .bus2ip_wr_ce_i(wr_ce),
    .ip2bus_data_o (rdata),
    .int_src_i     (src),
    .int_ptp_o     (irq)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] d);
    addr  = BASE + ofs;
    wdata = d;
    wr_ce = 1'b1;
    tick();
    wr_ce = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] ofs, output logic [31:0] d);
    addr  = BASE + ofs;
    rd_ce = 1'b1;
    #1;
    d     = rdata;
    rd_ce = 1'b0;
  endtask

  task automatic chk_rd(input string name, input logic [31:0] ofs, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(ofs, d);
    check(name, d, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] ofs;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit w, input logic [31:0] o, input logic [31:0] d,
                     input logic [31:0] e, input bit ei, input string nm);
    vec_t v;
    v.is_wr = w; v.ofs = o; v.data = d; v.exp_rd = e; v.exp_irq = ei; v.name = nm;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_status, m_mask, m_mode;
  logic         m_irq;
  logic [N-1:0] hist[$];

  task automatic model_reset();
    m_status = '0;
    m_mask   = '1;
    m_mode   = '0;
    m_irq    = 1'b0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back('0);
  endtask

  // Called at each rising edge, before inputs move: hist[k] is the input
  // sampled k+1 edges ago, so the synchronised level lags S samples.
  task automatic model_step();
    logic [N-1:0] sy, pv, set, w1c, frc;
    logic [31:0]  off;
    sy  = hist[S-1];
    pv  = hist[S];
    off = addr - BASE;
    w1c = (wr_ce && off == 32'd0) ? wdata[N-1:0] : '0;
    frc = (wr_ce && off == 32'd4) ? wdata[N-1:0] : '0;
    set = (m_mode & sy) | (~m_mode & sy & ~pv) | frc;
    m_irq    = |(m_status & m_mask);
    m_status = (m_status & ~w1c) | set;
    if (wr_ce && off == 32'd1) m_mask = wdata[N-1:0];
    if (wr_ce && off == 32'd2) m_mode = wdata[N-1:0];
    hist.push_front(src);
    void'(hist.pop_back());
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off)
      32'd0:   return 32'(m_status);
      32'd1:   return 32'(m_mask);
      32'd2:   return 32'(m_mode);
      32'd3:   return 32'(hist[S-1]);
      32'd5:   return COAL ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [31:0] exp_d;
    int          r;

    rst = 1'b1; addr = '0; wdata = '0; rd_ce = 1'b0; wr_ce = 1'b0; src = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    add(0, 32'd0, 0, 32'h00, 0, "rst_status");
    add(0, 32'd1, 0, 32'hFF, 0, "rst_mask");
    add(0, 32'd2, 0, 32'h00, 0, "rst_mode");
    add(0, 32'd3, 0, 32'h00, 0, "rst_raw");
    add(0, 32'd4, 0, 32'h00, 0, "rst_force");
    add(0, 32'd5, 0, COAL ? 32'd1 : 32'd0, 0, "rst_coal_thr");
    add(0, 32'd6, 0, 32'h00, 0, "rst_coal_tmo");
    add(0, 32'd7, 0, 32'h00, 0, "rd_unmapped7");
    add(0, 32'hFFFF_FFFF, 0, 32'h00, 0, "rd_below_base");
    add(1, 32'd1, 32'h00, 0, 0, "wr_mask0");
    add(1, 32'd4, 32'h81, 0, 0, "force81");
    add(0, 32'd0, 0, 32'h81, 0, "status81_masked");
    add(1, 32'd1, 32'h80, 0, !COAL, "unmask80");
    add(0, 32'd1, 0, 32'h80, !COAL, "mask80");
    add(1, 32'd0, 32'h80, 0, 0, "w1c80");
    add(0, 32'd0, 0, 32'h01, 0, "status01");
    add(1, 32'd1, 32'hFFFF_FFFF, 0, !COAL, "mask_all");
    add(0, 32'd1, 0, 32'hFF, !COAL, "mask_upper_ignored");
    add(1, 32'd0, 32'hFF, 0, 0, "w1c_all");
    add(0, 32'd0, 0, 32'h00, 0, "status_clear");
    add(1, 32'd7, 32'hFFFF, 0, 0, "wr_unmapped");
    add(1, 32'd2, 32'hA5, 0, 0, "wr_modeA5");
    add(0, 32'd2, 0, 32'hA5, 0, "modeA5");
    add(1, 32'd2, 32'h00, 0, 0, "wr_mode0");
    add(1, 32'd4, 32'h02, 0, 1, "force02");
    add(0, 32'd0, 0, 32'h02, 1, "status02");
    add(1, 32'd0, 32'h02, 0, COAL, "w1c02");
    add(0, 32'd0, 0, 32'h00, 0, "status_final");

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) bus_wr(vecs[i].ofs, vecs[i].data);
      else chk_rd(vecs[i].name, vecs[i].ofs, vecs[i].exp_rd);
      tick();
      check({vecs[i].name, "_irq"}, irq, vecs[i].exp_irq);
    end

    // Edge mode: three-cycle pulse on source 3.
    src[3] = 1'b1;
    tick(); tick();
    chk_rd("edge_status_early", 32'd0, 32'h00);
    tick();
    chk_rd("edge_status_set", 32'd0, 32'h08);
    check("edge_irq_early", irq, 0);
    src[3] = 1'b0;
    tick();
    check("edge_irq_set", irq, 1);
    bus_wr(32'd0, 32'h08);
    chk_rd("edge_w1c_status", 32'd0, 32'h00);
    check("edge_irq_after_w1c", irq, 1);
    tick();
    check("edge_irq_drop1", irq, COAL);
    tick();
    check("edge_irq_drop2", irq, 0);

    // Level mode: W1C cannot clear while the input is held.
    bus_wr(32'd2, 32'h01);
    src[0] = 1'b1;
    repeat (4) tick();
    chk_rd("level_status", 32'd0, 32'h01);
    bus_wr(32'd0, 32'h01);
    tick();
    chk_rd("level_reset_again", 32'd0, 32'h01);
    src[0] = 1'b0;
    repeat (3) tick();
    bus_wr(32'd0, 32'h01);
    tick(); tick();
    chk_rd("level_released", 32'd0, 32'h00);
    check("level_irq_released", irq, 0);
    bus_wr(32'd2, 32'h00);

    // W1C colliding with a fresh edge on the same bit.
    bus_wr(32'd4, 32'h04);
    src[2] = 1'b1;
    tick(); tick();
    bus_wr(32'd0, 32'h04);
    chk_rd("collide_set_wins", 32'd0, 32'h04);
    src[2] = 1'b0;
    tick();
    bus_wr(32'd0, 32'h04);
    chk_rd("collide_cleared", 32'd0, 32'h00);
    repeat (3) tick();

`ifdef PTP_IRQ_COALESCE_EN
    bus_wr(32'd5, 32'd3);
    bus_wr(32'd6, 32'd0);
    chk_rd("coal_thr3", 32'd5, 32'd3);
    bus_wr(32'd4, 32'h01);
    tick(); tick();
    check("coal_evt1", irq, 0);
    bus_wr(32'd4, 32'h02);
    tick(); tick();
    check("coal_evt2", irq, 0);
    bus_wr(32'd4, 32'h04);
    check("coal_evt3_pre", irq, 0);
    tick();
    check("coal_evt3", irq, 1);
    chk_rd("coal_status7", 32'd0, 32'h07);
    bus_wr(32'd0, 32'h07);
    repeat (3) tick();
    check("coal_cleared", irq, 0);
    bus_wr(32'd5, 32'd200);
    bus_wr(32'd6, 32'd10);
    chk_rd("coal_tmo10", 32'd6, 32'd10);
    bus_wr(32'd4, 32'h01);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("coal_tmo_early", irq, 0);
    end
    tick();
    check("coal_tmo_fire", irq, 1);
    bus_wr(32'd0, 32'h01);
    repeat (3) tick();
    check("coal_tmo_cleared", irq, 0);
`else
    bus_wr(32'd5, 32'd3);
    bus_wr(32'd6, 32'd9);
    chk_rd("nocoal_thr_ro0", 32'd5, 32'd0);
    chk_rd("nocoal_tmo_ro0", 32'd6, 32'd0);
`endif

    // Reset mid-operation with source 5 held high throughout.
    bus_wr(32'd4, 32'h10);
    src[5] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("rst_irq_low", irq, 0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk_rd("rst_hold_status", 32'd0, 32'h00);
    chk_rd("rst_hold_mask", 32'd1, 32'hFF);
    chk_rd("rst_hold_raw", 32'd3, 32'h20);
    check("rst_hold_irq", irq, 0);
    src = '0;
    repeat (4) tick();

    // Randomized traffic against the reference model.
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= 3 && cyc % 3 == 0) src = N'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: addr = BASE;
        4:          addr = BASE + 32'd1;
        5:          addr = BASE + 32'd2;
        6:          addr = BASE + 32'd4;
        7:          addr = BASE + 32'd3;
        8:          addr = BASE + 32'd7;
        default:    addr = BASE - 32'd1;
      endcase
      wdata = $urandom;
      wr_ce = ($urandom_range(0, 2) == 0);
      rd_ce = ($urandom_range(0, 1) == 1);
      #1;
      exp_d = rd_ce ? model_read(addr) : 32'd0;
      check("rand_rdata", rdata, exp_d);
      @(posedge clk);
      model_step();
      #1;
`ifndef PTP_IRQ_COALESCE_EN
      check("rand_irq", irq, m_irq);
`endif
    end
    wr_ce = 1'b0;
    rd_ce = 1'b0;
    tick();
    chk_rd("rand_final_status", 32'd0, model_read(BASE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
